// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: SYNC, length, MSB-first words, optional XOR checksum.
// Define IMEM_LOADER_CHKSUM_EN to add the CHK state and the err/ERR path.
module imem_loader #(
    parameter int unsigned W    = 32,
    parameter int unsigned N    = 8,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] mem_addr,
    output logic [W-1:0] mem_data,
    output logic         mem_cs,
    output logic         mem_we,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int unsigned BYTES = W / 8;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CW    = N + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bidx_q, bidx_d;
    logic [W-1:0]    word_q, word_d;
    logic            accept;
    logic            ready_d, write_d, done_d, hold_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]      chk_q, chk_d;
    logic            err_d;
`endif

    // in_ready is registered from the next state, so it always reflects the current state.
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        hold_d  = cpu_hold;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_d   = chk_q;
        err_d   = err;
`endif
        case (state_q)
            IDLE: begin
                if (accept && in_data == SYNC) begin
                    state_d = LEN;
                    hold_d  = 1'b1;
                end
            end
            LEN: begin
                if (accept) begin
                    cnt_d   = (in_data == 8'h00) ? {1'b1, N'(0)} : CW'(in_data);
                    addr_d  = '0;
                    bidx_d  = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d   = '0;
`endif
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    word_d = W'({word_q, in_data});
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d  = chk_q ^ in_data;
`endif
                    if (bidx_q == BW'(BYTES - 1)) begin
                        bidx_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bidx_d  = bidx_q + BW'(1);
                    end
                end
            end
            WRITE: begin
                addr_d = addr_q + N'(1);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end
            end
            ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ready_d = !(state_d == WRITE || state_d == DONE);
        write_d = (state_d == WRITE);
        done_d  = (state_d == DONE);
        if (state_d == DONE) begin
            hold_d = 1'b0;
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        if (state_d == DONE) begin
            err_d = 1'b0;
        end else if (state_d == ERR) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            in_ready <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            in_ready <= ready_d;
            mem_cs   <= write_d;
            mem_we   <= write_d;
            cpu_hold <= hold_d;
            done     <= done_d;
            if (write_d) begin
                mem_addr <= addr_q;
                mem_data <= word_d;
            end
        end
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q <= '0;
            err   <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err   <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter W, default 32, instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter N, default 8, instruction-memory address width.
REQ-003 Parameter SYNC, default 8'hA5, frame start byte.
REQ-004 clk  input  1  the single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_data  input  8  received byte.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  loader accepts a byte; transfer when in_valid & in_ready on a rising edge.
REQ-009 mem_addr  output  N  instruction-memory write address.
REQ-010 mem_data  output  W  instruction-memory write data.
REQ-011 mem_cs, mem_we  output  1 each  instruction-memory chip select and write enable.
REQ-012 cpu_hold  output  1  holds the processor in reset while a program is loading.
REQ-013 done  output  1  one-cycle pulse on successful frame completion.
REQ-014 err  output  1  sticky frame-error flag.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-016 IDLE: in_ready=1; accepted byte == SYNC -> LEN and cpu_hold=1; any other byte is discarded.
REQ-017 LEN: in_ready=1; accepted byte L sets word count = L, or 2**N when L=0; address counter cleared to 0; -> DATA.
REQ-018 DATA: in_ready=1; bytes SHALL assemble MSB-first into a W-bit word; after the (W/8)th byte -> WRITE.
REQ-019 WRITE: exactly one cycle; in_ready=0; mem_cs=1, mem_we=1, mem_addr=address counter, mem_data=assembled word; in_valid is ignored.
REQ-020 After WRITE the address increments modulo 2**N and the word count decrements; count nonzero -> DATA, else -> CHK (macro defined) or DONE.
REQ-021 mem_cs and mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_data hold their last values outside WRITE.
REQ-022 DONE: one cycle; done=1, cpu_hold=0, err=0; -> IDLE.
REQ-023 ERR: err=1, cpu_hold stays 1, in_ready=1; accepted SYNC byte clears err and -> LEN; other bytes are discarded.
REQ-024 Write throughput: one word per W/8 accepted bytes plus one WRITE cycle; first write occurs the cycle after the last byte of the word is accepted.
REQ-025 The byte-transfer handshake tolerates in_valid gaps of any length in any accepting state without loss or duplication.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, in_ready=0 while asserted, and mem_cs=mem_we=cpu_hold=done=err=0, mem_addr=0, mem_data=0, counters and checksum=0.
REQ-027 Reset mid-frame abandons the frame; memory words already written are not reverted; after release, in_ready=1 in IDLE from the first clock edge.

Configuration
REQ-028 Macro IMEM_LOADER_CHKSUM_EN defined: CHK state present; running XOR of all data bytes of the frame is compared to the byte accepted in CHK; match -> DONE, mismatch -> ERR.
REQ-029 IMEM_LOADER_CHKSUM_EN undefined: no CHK state or checksum logic; last WRITE -> DONE directly; err is constant 0 and ERR state is unreachable.

Verification
REQ-030 Bytes A5,01,12,34,56,78 (W=32) -> one write mem_addr=0x00, mem_data=0x12345678; cpu_hold high from A5 until DONE; done pulses once.
REQ-031 Bytes 00,FF,A5,02 then 8 data bytes 11..88 -> leading 00,FF discarded; writes 0x11223344 @0x00 and 0x55667788 @0x01.
REQ-032 CHK_EN: A5,01,DE,AD,BE,EF,22 -> DONE; same frame ending 23 -> err=1, cpu_hold=1, no done; subsequent A5 clears err.
REQ-033 L=00 with 1024 data bytes -> 256 writes, addresses 0x00..0xFF, done once; in_valid held high shows in_ready=0 only in WRITE cycles.
REQ-034 reset=0 asserted after two data bytes of word 1 -> all outputs 0 immediately; new frame A5,01,CA,FE,BA,BE after release writes 0xCAFEBABE @0x00.
REQ-035 Random in_valid gaps on frame of REQ-031 -> identical write sequence and values.
